// File: rtl/game_controller.sv
// Tilt-maze game controller: level selection, lives, movement strobes,
// play timer and status colour.
module game_controller #(
  parameter int unsigned LVL_W     = 2,
  parameter int unsigned MAX_LIVES = 3,
  parameter int unsigned TILT_W    = 8,
  parameter int unsigned DEADZONE  = 16,
  parameter int unsigned TIME_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LVL_W-1:0]  level_select,
  input  logic              level_lock,
  input  logic              restart_n,
  input  logic [TILT_W-1:0] tilt_x,
  input  logic [TILT_W-1:0] tilt_y,
  input  logic              at_finish,
  input  logic              collision,
  input  logic              tick,
  output logic [2:0]        top_state,
  output logic [LVL_W-1:0]  active_level,
  output logic [3:0]        lives,
  output logic              move_l,
  output logic              move_r,
  output logic              move_u,
  output logic              move_d,
  output logic [TIME_W-1:0] elapsed,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SPAWN  = 3'd2,
    MOVE   = 3'd3,
    STILL  = 3'd4,
    DONE   = 3'd5,
    OVER   = 3'd6
  } state_t;

  localparam logic [TILT_W:0]   DZ         = (TILT_W+1)'(DEADZONE);
  localparam logic [3:0]        LIVES_INIT = 4'(MAX_LIVES);
  localparam logic [TIME_W-1:0] TIME_MAX   = '1;

  state_t              state, state_nx;
  logic [LVL_W-1:0]    level_nx;
  logic [3:0]          lives_nx;
  logic [TIME_W-1:0]   elapsed_nx;
  logic [3:0]          strobe_nx;
  logic [11:0]         rgb_nx;
  logic [TILT_W:0]     mag_x_c, mag_y_c;
  logic                tilt_x_c, tilt_y_c, tilted_c;

  // Magnitude one bit wider than the sample so the most negative value does not wrap.
  function automatic logic [TILT_W:0] magnitude(input logic [TILT_W-1:0] v);
    logic [TILT_W:0] ext;
    ext = {v[TILT_W-1], v};
    return v[TILT_W-1] ? (TILT_W+1)'(-ext) : ext;
  endfunction

  assign mag_x_c  = magnitude(tilt_x);
  assign mag_y_c  = magnitude(tilt_y);
  assign tilt_x_c = mag_x_c > DZ;
  assign tilt_y_c = mag_y_c > DZ;
  assign tilted_c = tilt_x_c | tilt_y_c;
  assign top_state = state;

  // Next-state and next-output logic.
  always_comb begin
    state_nx   = state;
    level_nx   = active_level;
    lives_nx   = lives;
    elapsed_nx = elapsed;
    strobe_nx  = 4'b0000;
    rgb_nx     = 12'h000;

    if ((state == MOVE || state == STILL) && tick && elapsed != TIME_MAX)
      elapsed_nx = elapsed + TIME_W'(1);

    case (state)
      IDLE: if (level_select != '0) state_nx = SELECT;
      SELECT: begin
        if (level_select == '0) state_nx = IDLE;
        else if (level_lock) begin
          state_nx   = SPAWN;
          level_nx   = level_select;
          lives_nx   = LIVES_INIT;
          elapsed_nx = '0;
        end
      end
      default: begin
        if (!level_lock) state_nx = SELECT;
        else begin
          case (state)
            SPAWN: if (tilted_c) state_nx = MOVE;
            MOVE, STILL: begin
              if (at_finish) state_nx = DONE;
              else if (collision) begin
                if (lives == 4'd1) begin
                  lives_nx = 4'd0;
                  state_nx = OVER;
                end else begin
                  lives_nx = lives - 4'd1;
                  state_nx = SPAWN;
                end
              end else state_nx = tilted_c ? MOVE : STILL;
            end
            DONE: if (!restart_n) begin
              state_nx   = SPAWN;
              lives_nx   = LIVES_INIT;
              elapsed_nx = '0;
            end
            OVER: if (!restart_n) state_nx = SELECT;
            default: state_nx = IDLE;
          endcase
        end
      end
    endcase

    // Strobes order: l, r, u, d.
    if (state_nx == MOVE)
      strobe_nx = {tilt_x_c &  tilt_x[TILT_W-1], tilt_x_c & ~tilt_x[TILT_W-1],
                   tilt_y_c & ~tilt_y[TILT_W-1], tilt_y_c &  tilt_y[TILT_W-1]};

    case (state_nx)
      SELECT:      rgb_nx = 12'h00F;
      SPAWN:       rgb_nx = 12'h080;
      MOVE, STILL: rgb_nx = 12'h0F0;
      DONE:        rgb_nx = 12'hFFF;
      OVER:        rgb_nx = 12'hF00;
      default:     rgb_nx = 12'h000;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      active_level <= '0;
      lives        <= 4'd0;
      elapsed      <= '0;
      {move_l, move_r, move_u, move_d} <= 4'b0000;
      {red, green, blue} <= 12'h000;
    end else begin
      state        <= state_nx;
      active_level <= level_nx;
      lives        <= lives_nx;
      elapsed      <= elapsed_nx;
      {move_l, move_r, move_u, move_d} <= strobe_nx;
      {red, green, blue} <= rgb_nx;
    end
  end

endmodule
